// File: rtl/gat_bram_load_ctrl.sv
// gat_bram_load_ctrl: registered host-to-core BRAM load path for the GAT core.
// Converts host byte addresses to word addresses, truncates host data to the
// internal width, rejects misaligned and out-of-range writes, counts accepted
// words per channel and sequences core start / run / result-ready.
// Build option: define GAT_LOAD_CKSUM_EN to add per-channel checksums of
// accepted (truncated) data on dbg_cksum; otherwise dbg_cksum is tied to 0.
//
// state | meaning
// IDLE  | out of reset, waiting for the first accepted write
// LOAD  | accepting writes, waiting for every channel to complete
// RUN   | core started, host writes rejected, waiting for core_done
// DONE  | result valid (gat_ready); an accepted write starts a reload
module gat_bram_load_ctrl #(
  parameter int TOP_WIDTH  = 32,
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_W     = 18,
  parameter int BYTE_OFF   = $clog2(TOP_WIDTH / 8)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH*TOP_WIDTH-1:0]         host_din,
  input  logic [NUM_CH-1:0]                   host_ena,
  input  logic [NUM_CH-1:0]                   host_wea,
  input  logic [NUM_CH*(ADDR_W+BYTE_OFF)-1:0] host_addra,
  input  logic [NUM_CH-1:0]                   host_load_done,
  input  logic [NUM_CH*(ADDR_W+1)-1:0]        cfg_depth,
  input  logic                                core_done,
  output logic [NUM_CH*DATA_WIDTH-1:0]        bram_din,
  output logic [NUM_CH-1:0]                   bram_ena,
  output logic [NUM_CH-1:0]                   bram_wea,
  output logic [NUM_CH*ADDR_W-1:0]            bram_addra,
  output logic                                core_start,
  output logic                                gat_ready,
  output logic [TOP_WIDTH-1:0]                dbg_status,
  output logic [NUM_CH*TOP_WIDTH-1:0]         dbg_cksum
);

  localparam int HA_W  = ADDR_W + BYTE_OFF;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [HA_W-1:0]  OFF_MASK = HA_W'((64'd1 << BYTE_OFF) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   start_next;

  logic [HA_W-1:0]       haddr [NUM_CH];
  logic [ADDR_W-1:0]     waddr [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata [NUM_CH];
  logic [CNT_W-1:0]      depth [NUM_CH];
  logic [NUM_CH-1:0]     wr_req;
  logic [NUM_CH-1:0]     mis;
  logic [NUM_CH-1:0]     rng_bad;
  logic [NUM_CH-1:0]     accept;
  logic                  any_accept;
  logic                  reload;

  logic [CNT_W-1:0]      wcnt [NUM_CH];
  logic [NUM_CH-1:0]     ld_flag;
  logic [NUM_CH-1:0]     ch_done;
  logic [NUM_CH-1:0]     err_mis;
  logic [NUM_CH-1:0]     err_rng;
  logic                  err_run;

  // Upper host data bits are intentionally discarded; this sink keeps them visible.
  logic unused_din;
  assign unused_din = ^host_din;

  // Per-channel address/data decode and write acceptance.
  always_comb begin
    wr_req  = '0;
    mis     = '0;
    rng_bad = '0;
    accept  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      haddr[c]   = host_addra[c*HA_W +: HA_W];
      waddr[c]   = ADDR_W'(haddr[c] >> BYTE_OFF);
      wdata[c]   = host_din[c*TOP_WIDTH +: DATA_WIDTH];
      depth[c]   = cfg_depth[c*CNT_W +: CNT_W];
      wr_req[c]  = host_ena[c] & host_wea[c];
      mis[c]     = (haddr[c] & OFF_MASK) != '0;
      rng_bad[c] = {1'b0, waddr[c]} >= depth[c];
      accept[c]  = wr_req[c] & (state != RUN) & ~mis[c] & ~rng_bad[c];
    end
  end

  assign any_accept = |accept;
  assign reload     = (state == DONE) && any_accept;

  // Sequencer state and start-pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      core_start <= 1'b0;
    end else begin
      state      <= state_next;
      core_start <= start_next;
    end
  end

  // Next-state decode; core_done only matters in RUN.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    case (state)
      IDLE: if (any_accept) state_next = LOAD;
      LOAD: begin
        if (&ch_done) begin
          state_next = RUN;
          start_next = 1'b1;
        end
      end
      RUN:  if (core_done) state_next = DONE;
      DONE: if (any_accept) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Result-valid level: set when the core finishes, cleared by a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      gat_ready <= 1'b0;
    end else if ((state == RUN) && core_done) begin
      gat_ready <= 1'b1;
    end else if (reload) begin
      gat_ready <= 1'b0;
    end
  end

  // Registered BRAM write path, word counters, completion and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_din   <= '0;
      bram_ena   <= '0;
      bram_wea   <= '0;
      bram_addra <= '0;
      ld_flag    <= '0;
      ch_done    <= '0;
      err_mis    <= '0;
      err_rng    <= '0;
      err_run    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) wcnt[c] <= '0;
    end else begin
      bram_ena <= accept;
      bram_wea <= accept;
      if ((state == RUN) && (|wr_req)) err_run <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          bram_din[c*DATA_WIDTH +: DATA_WIDTH] <= wdata[c];
          bram_addra[c*ADDR_W +: ADDR_W]       <= waddr[c];
        end
        if (wr_req[c] && mis[c])     err_mis[c] <= 1'b1;
        if (wr_req[c] && rng_bad[c]) err_rng[c] <= 1'b1;
        // A reload restarts the count with the accepting write as word 1.
        if (reload) begin
          wcnt[c]    <= accept[c] ? CNT_W'(1) : '0;
          ld_flag[c] <= host_load_done[c];
          ch_done[c] <= 1'b0;
        end else begin
          if (accept[c] && (wcnt[c] != CNT_MAX)) wcnt[c] <= wcnt[c] + CNT_W'(1);
          if (host_load_done[c]) ld_flag[c] <= 1'b1;
          ch_done[c] <= ld_flag[c] && (wcnt[c] >= depth[c]);
        end
      end
    end
  end

  // Status word assembled from the registered flags; layout assumes TOP_WIDTH >= 32.
  always_comb begin
    dbg_status          = '0;
    dbg_status[1:0]     = state;
    dbg_status[2 +: 8]  = 8'(ch_done);
    dbg_status[10 +: 8] = 8'(err_mis);
    dbg_status[18 +: 8] = 8'(err_rng);
    dbg_status[26]      = err_run;
  end

`ifdef GAT_LOAD_CKSUM_EN
  logic [TOP_WIDTH-1:0] cksum [NUM_CH];

  // Running sum of accepted truncated data, restarted by a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) cksum[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reload) begin
          cksum[c] <= accept[c] ? TOP_WIDTH'(wdata[c]) : '0;
        end else if (accept[c]) begin
          cksum[c] <= cksum[c] + TOP_WIDTH'(wdata[c]);
        end
      end
    end
  end

  // Pack per-channel checksums onto the debug bus.
  always_comb begin
    dbg_cksum = '0;
    for (int c = 0; c < NUM_CH; c++) dbg_cksum[c*TOP_WIDTH +: TOP_WIDTH] = cksum[c];
  end
`else
  assign dbg_cksum = '0;
`endif

endmodule

// File: doc/gat_bram_load_ctrl.md
# gat_bram_load_ctrl

Multi-channel host-to-accelerator BRAM load controller that sits between the PS-side 32-bit, byte-addressed BRAM ports and the word-addressed, narrow internal BRAMs of the GAT core. It replaces static slicing with a registered per-channel path that:
- converts byte addresses to word addresses and truncates data to the internal width;
- rejects misaligned and out-of-range writes;
- counts accepted words per channel, tracks load completion, and sequences core start, run and ready.

## Interface
- TOP_WIDTH, 32, host bus data width (multiple of 8)
- NUM_CH, 4, number of load channels (1..8)
- DATA_WIDTH, 20, internal BRAM data width (≤ TOP_WIDTH); host bits above it are discarded
- ADDR_W, 18, internal word-address width
- BYTE_OFF, $clog2(TOP_WIDTH/8), byte-offset bits stripped from host addresses
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- host_din  in  NUM_CH*TOP_WIDTH  per-channel write data, channel c at [c*TOP_WIDTH +: TOP_WIDTH]
- host_ena  in  NUM_CH  per-channel enable
- host_wea  in  NUM_CH  per-channel write enable; a write requires ena&wea
- host_addra  in  NUM_CH*(ADDR_W+BYTE_OFF)  per-channel byte address
- host_load_done  in  NUM_CH  register-bank load-done level or pulse; latched as sticky per channel
- cfg_depth  in  NUM_CH*(ADDR_W+1)  expected word count per channel; sampled live
- core_done  in  1  one-cycle pulse from the GAT core
- bram_din  out  NUM_CH*DATA_WIDTH  registered internal write data
- bram_ena, bram_wea  out  NUM_CH  registered write strobes
- bram_addra  out  NUM_CH*ADDR_W  registered word address
- core_start  out  1  one-cycle start pulse
- gat_ready  out  1  result-valid level
- dbg_status  out  TOP_WIDTH  status word
- dbg_cksum  out  NUM_CH*TOP_WIDTH  per-channel checksum

## Operation
- States: IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE → LOAD on any accepted write.
- A write on channel c is accepted only when all of the following hold:
  - state is IDLE, LOAD or DONE;
  - the low BYTE_OFF address bits are 0;
  - the word address addr[ADDR_W+BYTE_OFF-1:BYTE_OFF] is < cfg_depth[c].
- On accept:
  - bram_* for channel c carries din[DATA_WIDTH-1:0], the word address, ena=wea=1;
  - wcnt[c] increments, saturating at 2^(ADDR_W+1)-1.
- Rejected writes:
  - bram_ena/wea stay 0;
  - a misaligned address sets sticky err_mis[c];
  - an out-of-range address sets sticky err_rng[c];
  - a write in RUN sets sticky err_run.
- ld_flag[c] is set when host_load_done[c]=1.
- ch_done[c] is registered as ld_flag[c] && wcnt[c] ≥ cfg_depth[c]. When cfg_depth[c]=0, ld_flag alone completes the channel.
- LOAD → RUN at the first edge where &ch_done=1. core_start is 1 for exactly the following cycle.
- RUN → DONE on core_done; gat_ready is set at the same edge. core_done is ignored in every other state.
- DONE → LOAD on an accepted write (reload). At that edge:
  - gat_ready, wcnt, ld_flag, ch_done and checksums clear; the accepting write counts as word 1.
  - Error flags are not cleared; only rst clears them.
- dbg_status bit layout:
  - [1:0] state;
  - [2+:8] ch_done, zero-extended;
  - [10+:8] err_mis;
  - [18+:8] err_rng;
  - [26] err_run;
  - [31:27] 0.

## Timing
- Accepted host write in cycle N → bram_* valid in cycle N+1 and wcnt updated at the N+1 edge. Latency is 1; throughput is one write per channel per cycle, with all channels concurrent.
- A write and load_done in the same cycle:
  - ch_done registers at edge N+2;
  - the state enters RUN at N+3;
  - core_start is high in cycle N+3.
- Reset values:
  - all bram_* outputs 0;
  - core_start 0, gat_ready 0;
  - dbg_status 0 (state IDLE);
  - dbg_cksum 0;
  - all counters and flags 0.
- rst mid-LOAD or mid-RUN aborts immediately. A core_done arriving after reset is ignored.
- A write in the same cycle as core_done in RUN is rejected (err_run set).

## Configuration
- GAT_LOAD_CKSUM_EN defined:
  - dbg_cksum[c] = mod-2^32 sum of accepted truncated data on channel c, zero-extended;
  - updates in the same cycle as wcnt;
  - clears on reload and rst.
- GAT_LOAD_CKSUM_EN undefined: dbg_cksum is tied to 0 and no adders are present.

## Test plan
- **Basic load:** NUM_CH=4, cfg_depth=8 on every channel; write 8 aligned words per channel (byte addresses 0,4,…,28), then pulse load_done.
  - bram_addra = 0..7 with 1-cycle latency;
  - core_start is a single pulse 2 cycles after the last flag is latched;
  - dbg_status[1:0]=2.
- **Rejects:** write address 0x6 on ch1 and address 36 with cfg_depth=8 on ch2.
  - No bram_ena on either channel;
  - dbg_status[11]=1 (err_mis ch1) and dbg_status[20]=1 (err_rng ch2);
  - wcnt is unchanged.
- **Early load_done:** ch0 load_done arrives with 7/8 words written.
  - No core_start;
  - after the 8th write, core_start fires 2 cycles later.
- **Run and reload:** pulse core_done in RUN.
  - gat_ready=1 next cycle.
  - A write in RUN sets err_run; a write in DONE returns the state to LOAD and clears gat_ready.
- **Truncation and checksum:** with the macro on and DATA_WIDTH=20, write 0xFFF12345 then 0x00000001.
  - bram_din = 0x12345, then 0x00001;
  - dbg_cksum = 0x12346.
- **Reset mid-LOAD:** assert rst while in LOAD.
  - All outputs return to 0 next cycle;
  - a following core_done pulse has no effect.
